// File: rtl/olink_tx_framer.sv
// olink_tx_framer: transmit framer for the polink GTX lane. Serialises 32-bit words (4 K flags)
// as 16-bit tx_d/tx_k half-words, low half first, and inserts sequenced commas, pads and idles
// so the far end can phase-align on 32-bit boundaries.
// Latency: a word chosen at slot start appears as low half 1 cycle later, high half 2 cycles later.
// Backpressure: in_rdy is combinational, only high at slot start in RUN with link up and no comma due.
// Ports: clk_link/reset_n (async active-low); link_ready, force_comma, counter_reset controls;
//   in_d/in_k/in_v/in_rdy word input; tx_d/tx_k to the GT; cnt_words/cnt_commas/cnt_bad statistics;
//   running = steady state. Optional capture buffer (spy_start/spy_addr/spy_dout) when
//   OLINK_TX_SPY_EN is defined.
module olink_tx_framer #(
  parameter int COMMA_PERIOD   = 64,
  parameter int STARTUP_COMMAS = 16,
  parameter int CNT_W          = 32
) (
  input  logic             clk_link,
  input  logic             reset_n,
  input  logic             link_ready,
  input  logic             force_comma,
  input  logic             counter_reset,
  input  logic [31:0]      in_d,
  input  logic [3:0]       in_k,
  input  logic             in_v,
  output logic             in_rdy,
  output logic [15:0]      tx_d,
  output logic [1:0]       tx_k,
  output logic [CNT_W-1:0] cnt_words,
  output logic [CNT_W-1:0] cnt_commas,
  output logic [CNT_W-1:0] cnt_bad,
  output logic             running
`ifdef OLINK_TX_SPY_EN
  ,
  input  logic             spy_start,
  input  logic [5:0]       spy_addr,
  output logic [31:0]      spy_dout
`endif
);

  localparam int TMR_W = $clog2(COMMA_PERIOD);
  localparam int SUC_W = $clog2(STARTUP_COMMAS + 1);
  localparam logic [TMR_W-1:0] TMR_MAX  = TMR_W'(COMMA_PERIOD - 1);
  localparam logic [SUC_W-1:0] SUC_LAST = SUC_W'(STARTUP_COMMAS - 1);

  typedef enum logic {ST_STARTUP, ST_RUN} state_e;
  typedef enum logic [1:0] {W_COMMA, W_DATA, W_PAD, W_IDLE} wsel_e;

  state_e           state_q, state_d;
  logic             phase_q, phase_d;
  logic [7:0]       seq_q, seq_d;
  logic [TMR_W-1:0] tmr_q, tmr_d;
  logic [SUC_W-1:0] suc_q, suc_d;
  logic             force_pend_q, force_pend_d;
  logic [15:0]      hi_d_q, hi_d_d;
  logic [1:0]       hi_k_q, hi_k_d;
  logic [15:0]      tx_d_q, tx_d_d;
  logic [1:0]       tx_k_q, tx_k_d;
  logic [CNT_W-1:0] cnt_words_q, cnt_words_d;
  logic [CNT_W-1:0] cnt_commas_q, cnt_commas_d;
  logic [CNT_W-1:0] cnt_bad_q, cnt_bad_d;

  logic        slot;
  logic        comma_due;
  logic        in_k_ok;
  wsel_e       wsel;
  logic [31:0] word_d;
  logic [3:0]  word_k;
  logic        send_comma, send_data, send_pad;

  function automatic logic [CNT_W-1:0] cnt_next(input logic [CNT_W-1:0] cur,
                                                input logic inc, input logic clr);
    logic [CNT_W-1:0] r;
    r = cur;
    if (clr)              r = '0;
    else if (inc && !(&cur)) r = cur + CNT_W'(1);
    return r;
  endfunction

  // Word selection happens only in the phase-0 cycle; the result is split across two cycles.
  always_comb begin
    slot      = !phase_q;
    comma_due = force_pend_q || (tmr_q == TMR_MAX);
    in_k_ok   = (in_k == 4'h0) || (in_k == 4'hF);
    in_rdy    = slot && (state_q == ST_RUN) && link_ready && !comma_due;

    if ((state_q != ST_RUN) || !link_ready || comma_due) wsel = W_COMMA;
    else if (in_v && in_k_ok)                            wsel = W_DATA;
    else if (in_v)                                       wsel = W_PAD;
    else                                                 wsel = W_IDLE;

    case (wsel)
      W_COMMA: begin word_d = {16'h0000, seq_q, 8'hBC}; word_k = 4'b0001; end
      W_DATA:  begin word_d = in_d;                     word_k = in_k;    end
      W_PAD:   begin word_d = 32'h1C1C_1C1C;            word_k = 4'hF;    end
      default: begin word_d = 32'hF7F7_F7F7;            word_k = 4'hF;    end
    endcase

    send_comma = slot && (wsel == W_COMMA);
    send_data  = slot && (wsel == W_DATA);
    send_pad   = slot && (wsel == W_PAD);
  end

  always_comb begin
    phase_d = !phase_q;
    hi_d_d  = hi_d_q;
    hi_k_d  = hi_k_q;
    if (slot) begin
      tx_d_d = word_d[15:0];
      tx_k_d = word_k[1:0];
      hi_d_d = word_d[31:16];
      hi_k_d = word_k[3:2];
    end else begin
      tx_d_d = hi_d_q;
      tx_k_d = hi_k_q;
    end

    seq_d = send_comma ? seq_q + 8'd1 : seq_q;

    if (send_comma)                 tmr_d = '0;
    else if (slot && tmr_q != TMR_MAX) tmr_d = tmr_q + TMR_W'(1);
    else                            tmr_d = tmr_q;

    // A pulse seen in the slot-start cycle of a comma belongs to the following slot.
    force_pend_d = send_comma ? force_comma : (force_pend_q || force_comma);

    // Startup commas only count while the link stays up; any drop restarts the count.
    state_d = state_q;
    suc_d   = suc_q;
    if (!link_ready) begin
      suc_d = '0;
      if (slot) state_d = ST_STARTUP;
    end else if ((state_q == ST_STARTUP) && send_comma) begin
      if (suc_q == SUC_LAST) begin
        state_d = ST_RUN;
        suc_d   = '0;
      end else begin
        suc_d = suc_q + SUC_W'(1);
      end
    end

    cnt_words_d  = cnt_next(cnt_words_q,  send_data,  counter_reset);
    cnt_commas_d = cnt_next(cnt_commas_q, send_comma, counter_reset);
    cnt_bad_d    = cnt_next(cnt_bad_q,    send_pad,   counter_reset);
  end

  always_ff @(posedge clk_link or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_STARTUP;
      phase_q      <= 1'b0;
      seq_q        <= 8'd0;
      tmr_q        <= '0;
      suc_q        <= '0;
      force_pend_q <= 1'b0;
      hi_d_q       <= 16'hF7F7;
      hi_k_q       <= 2'b11;
      tx_d_q       <= 16'hF7F7;
      tx_k_q       <= 2'b11;
      cnt_words_q  <= '0;
      cnt_commas_q <= '0;
      cnt_bad_q    <= '0;
    end else begin
      state_q      <= state_d;
      phase_q      <= phase_d;
      seq_q        <= seq_d;
      tmr_q        <= tmr_d;
      suc_q        <= suc_d;
      force_pend_q <= force_pend_d;
      hi_d_q       <= hi_d_d;
      hi_k_q       <= hi_k_d;
      tx_d_q       <= tx_d_d;
      tx_k_q       <= tx_k_d;
      cnt_words_q  <= cnt_words_d;
      cnt_commas_q <= cnt_commas_d;
      cnt_bad_q    <= cnt_bad_d;
    end
  end

  assign tx_d       = tx_d_q;
  assign tx_k       = tx_k_q;
  assign cnt_words  = cnt_words_q;
  assign cnt_commas = cnt_commas_q;
  assign cnt_bad    = cnt_bad_q;
  assign running    = (state_q == ST_RUN);

`ifdef OLINK_TX_SPY_EN
  // Captures the registered line output each cycle until 64 entries are filled.
  logic [31:0] spy_mem [64];
  logic [5:0]  spy_ptr_q, spy_ptr_d;
  logic        spy_full_q, spy_full_d;
  logic [31:0] spy_dout_q;

  always_comb begin
    spy_ptr_d  = spy_ptr_q;
    spy_full_d = spy_full_q;
    if (spy_start) begin
      spy_ptr_d  = 6'd0;
      spy_full_d = 1'b0;
    end else if (!spy_full_q) begin
      if (spy_ptr_q == 6'd63) spy_full_d = 1'b1;
      else                    spy_ptr_d  = spy_ptr_q + 6'd1;
    end
  end

  always_ff @(posedge clk_link) begin
    if (!spy_start && !spy_full_q) spy_mem[spy_ptr_q] <= {14'h0, tx_k_q, tx_d_q};
  end

  always_ff @(posedge clk_link or negedge reset_n) begin
    if (!reset_n) begin
      spy_ptr_q  <= 6'd0;
      spy_full_q <= 1'b0;
      spy_dout_q <= 32'd0;
    end else begin
      spy_ptr_q  <= spy_ptr_d;
      spy_full_q <= spy_full_d;
      spy_dout_q <= spy_mem[spy_addr];
    end
  end

  assign spy_dout = spy_dout_q;
`endif

endmodule

// File: tb/tb_olink_tx_framer.sv
// Directed bench for olink_tx_framer: reset, startup commas, data/pad/idle words, periodic
// commas under continuous traffic, link drop and recovery, force_comma merging and seq wrap,
// counter clear.
module tb_olink_tx_framer;

  logic        clk_link = 1'b0;
  logic        reset_n;
  logic        link_ready;
  logic        force_comma;
  logic        counter_reset;
  logic [31:0] in_d;
  logic [3:0]  in_k;
  logic        in_v;
  logic        in_rdy;
  logic [15:0] tx_d;
  logic [1:0]  tx_k;
  logic [31:0] cnt_words;
  logic [31:0] cnt_commas;
  logic [31:0] cnt_bad;
  logic        running;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk_link = ~clk_link;

  olink_tx_framer #(.COMMA_PERIOD(64), .STARTUP_COMMAS(16), .CNT_W(32)) dut (
    .clk_link(clk_link), .reset_n(reset_n), .link_ready(link_ready),
    .force_comma(force_comma), .counter_reset(counter_reset),
    .in_d(in_d), .in_k(in_k), .in_v(in_v), .in_rdy(in_rdy),
    .tx_d(tx_d), .tx_k(tx_k),
    .cnt_words(cnt_words), .cnt_commas(cnt_commas), .cnt_bad(cnt_bad),
    .running(running)
  );

  // Advance one clock; outputs are sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk_link);
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; link_ready = 1'b1; force_comma = 1'b0; counter_reset = 1'b0;
    in_d = 32'h0; in_k = 4'h0; in_v = 1'b0;
    repeat (3) @(posedge clk_link);
    #1;
    n_tests++; if (tx_d !== 16'hF7F7) begin n_fail++; $display("FAIL reset_tx_d got %h want F7F7", tx_d); end
    n_tests++; if (tx_k !== 2'b11) begin n_fail++; $display("FAIL reset_tx_k got %b want 11", tx_k); end
    n_tests++; if (in_rdy !== 1'b0) begin n_fail++; $display("FAIL reset_in_rdy got %b want 0", in_rdy); end
    n_tests++; if (running !== 1'b0) begin n_fail++; $display("FAIL reset_running got %b want 0", running); end
    n_tests++; if ({cnt_words, cnt_commas, cnt_bad} !== 96'h0) begin n_fail++; $display("FAIL reset_counters got %h/%h/%h want 0", cnt_words, cnt_commas, cnt_bad); end
    @(negedge clk_link);
    reset_n = 1'b1;
  endtask

  // Slots 0..15: startup commas with seq 0..15; RUN entered on the edge that selects comma 15.
  task automatic test_startup();
    logic [15:0] exp_lo;
    for (int s = 0; s < 16; s++) begin
      n_tests++; if (in_rdy !== 1'b0) begin n_fail++; $display("FAIL startup_in_rdy slot %0d got %b want 0", s, in_rdy); end
      tick();
      exp_lo = {s[7:0], 8'hBC};
      n_tests++; if (tx_d !== exp_lo || tx_k !== 2'b01) begin n_fail++; $display("FAIL startup_comma_lo slot %0d got %h/%b want %h/01", s, tx_d, tx_k, exp_lo); end
      n_tests++; if (running !== (s == 15)) begin n_fail++; $display("FAIL startup_running slot %0d got %b want %b", s, running, s == 15); end
      tick();
      n_tests++; if (tx_d !== 16'h0000 || tx_k !== 2'b00) begin n_fail++; $display("FAIL startup_comma_hi slot %0d got %h/%b want 0000/00", s, tx_d, tx_k); end
    end
    n_tests++; if (cnt_commas !== 32'd16) begin n_fail++; $display("FAIL startup_cnt_commas got %0d want 16", cnt_commas); end
  endtask

  // Slot 16: one data word.
  task automatic test_data();
    n_tests++; if (in_rdy !== 1'b1) begin n_fail++; $display("FAIL data_in_rdy got %b want 1", in_rdy); end
    in_v = 1'b1; in_d = 32'hDEADBEEF; in_k = 4'h0;
    tick();
    in_v = 1'b0;
    n_tests++; if (tx_d !== 16'hBEEF || tx_k !== 2'b00) begin n_fail++; $display("FAIL data_lo got %h/%b want BEEF/00", tx_d, tx_k); end
    n_tests++; if (in_rdy !== 1'b0) begin n_fail++; $display("FAIL data_rdy_phase1 got %b want 0", in_rdy); end
    tick();
    n_tests++; if (tx_d !== 16'hDEAD || tx_k !== 2'b00) begin n_fail++; $display("FAIL data_hi got %h/%b want DEAD/00", tx_d, tx_k); end
    n_tests++; if (cnt_words !== 32'd1) begin n_fail++; $display("FAIL data_cnt_words got %0d want 1", cnt_words); end
  endtask

  // Slot 17: illegal K pattern becomes a pad; slot 18: idle.
  task automatic test_pad_idle();
    n_tests++; if (in_rdy !== 1'b1) begin n_fail++; $display("FAIL pad_in_rdy got %b want 1", in_rdy); end
    in_v = 1'b1; in_d = 32'h12345678; in_k = 4'b0101;
    tick();
    in_v = 1'b0; in_k = 4'h0;
    n_tests++; if (tx_d !== 16'h1C1C || tx_k !== 2'b11) begin n_fail++; $display("FAIL pad_lo got %h/%b want 1C1C/11", tx_d, tx_k); end
    tick();
    n_tests++; if (tx_d !== 16'h1C1C || tx_k !== 2'b11) begin n_fail++; $display("FAIL pad_hi got %h/%b want 1C1C/11", tx_d, tx_k); end
    n_tests++; if (cnt_bad !== 32'd1 || cnt_words !== 32'd1) begin n_fail++; $display("FAIL pad_counters got bad=%0d words=%0d want 1/1", cnt_bad, cnt_words); end
    tick();
    n_tests++; if (tx_d !== 16'hF7F7 || tx_k !== 2'b11) begin n_fail++; $display("FAIL idle_lo got %h/%b want F7F7/11", tx_d, tx_k); end
    tick();
    n_tests++; if (tx_d !== 16'hF7F7 || tx_k !== 2'b11) begin n_fail++; $display("FAIL idle_hi got %h/%b want F7F7/11", tx_d, tx_k); end
  endtask

  // Slots 19..150 with in_v held high: commas expected at slots 79 (seq 16) and 143 (seq 17).
  task automatic test_continuous();
    int          sent = 0;
    int          exp_idx = 0;
    logic [7:0]  exp_seq = 8'd16;
    logic        exp_comma;
    logic        acc;
    logic [31:0] exp_w;
    for (int s = 19; s <= 150; s++) begin
      exp_comma = ((s - 15) % 64) == 0;
      in_v = 1'b1; in_k = 4'h0; in_d = 32'h5000_0000 + sent;
      n_tests++; if (in_rdy !== !exp_comma) begin n_fail++; $display("FAIL cont_in_rdy slot %0d got %b want %b", s, in_rdy, !exp_comma); end
      acc = in_rdy;
      exp_w = exp_comma ? {16'h0000, exp_seq, 8'hBC} : 32'h5000_0000 + exp_idx;
      tick();
      if (acc) sent++;
      n_tests++; if (tx_d !== exp_w[15:0] || tx_k !== (exp_comma ? 2'b01 : 2'b00)) begin n_fail++; $display("FAIL cont_lo slot %0d got %h/%b want %h", s, tx_d, tx_k, exp_w[15:0]); end
      n_tests++; if (in_rdy !== 1'b0) begin n_fail++; $display("FAIL cont_rdy_phase1 slot %0d got %b want 0", s, in_rdy); end
      tick();
      n_tests++; if (tx_d !== exp_w[31:16] || tx_k !== 2'b00) begin n_fail++; $display("FAIL cont_hi slot %0d got %h/%b want %h/00", s, tx_d, tx_k, exp_w[31:16]); end
      if (exp_comma) exp_seq++;
      else exp_idx++;
    end
    in_v = 1'b0;
    n_tests++; if (cnt_words !== 32'd131) begin n_fail++; $display("FAIL cont_cnt_words got %0d want 131", cnt_words); end
    n_tests++; if (cnt_commas !== 32'd18) begin n_fail++; $display("FAIL cont_cnt_commas got %0d want 18", cnt_commas); end
  endtask

  // Slot 151 idle with link drop mid-slot; commas 152,153 while down; 154..169 startup; 170 data.
  task automatic test_link_drop();
    logic [15:0] exp_lo;
    tick();
    n_tests++; if (tx_d !== 16'hF7F7) begin n_fail++; $display("FAIL drop_idle_lo got %h want F7F7", tx_d); end
    link_ready = 1'b0;
    in_v = 1'b1; in_d = 32'hCAFEF00D; in_k = 4'h0;
    n_tests++; if (running !== 1'b1) begin n_fail++; $display("FAIL drop_running_midslot got %b want 1", running); end
    tick();
    n_tests++; if (tx_d !== 16'hF7F7 || tx_k !== 2'b11) begin n_fail++; $display("FAIL drop_high_half got %h/%b want F7F7/11", tx_d, tx_k); end
    n_tests++; if (in_rdy !== 1'b0) begin n_fail++; $display("FAIL drop_in_rdy got %b want 0", in_rdy); end
    tick();
    n_tests++; if (tx_d !== 16'h12BC || tx_k !== 2'b01) begin n_fail++; $display("FAIL drop_comma_lo got %h/%b want 12BC/01", tx_d, tx_k); end
    n_tests++; if (running !== 1'b0) begin n_fail++; $display("FAIL drop_running got %b want 0", running); end
    tick();
    n_tests++; if (tx_d !== 16'h0000) begin n_fail++; $display("FAIL drop_comma_hi got %h want 0000", tx_d); end
    tick();
    n_tests++; if (tx_d !== 16'h13BC) begin n_fail++; $display("FAIL down_comma_lo got %h want 13BC", tx_d); end
    tick();
    link_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      n_tests++; if (in_rdy !== 1'b0) begin n_fail++; $display("FAIL recover_in_rdy %0d got %b want 0", i, in_rdy); end
      tick();
      exp_lo = {8'(20 + i), 8'hBC};
      n_tests++; if (tx_d !== exp_lo || tx_k !== 2'b01) begin n_fail++; $display("FAIL recover_comma_lo %0d got %h/%b want %h/01", i, tx_d, tx_k, exp_lo); end
      n_tests++; if (running !== (i == 15)) begin n_fail++; $display("FAIL recover_running %0d got %b want %b", i, running, i == 15); end
      tick();
    end
    n_tests++; if (in_rdy !== 1'b1) begin n_fail++; $display("FAIL recover_rdy_run got %b want 1", in_rdy); end
    tick();
    in_v = 1'b0;
    n_tests++; if (tx_d !== 16'hF00D || tx_k !== 2'b00) begin n_fail++; $display("FAIL recover_data_lo got %h/%b want F00D/00", tx_d, tx_k); end
    tick();
    n_tests++; if (tx_d !== 16'hCAFE) begin n_fail++; $display("FAIL recover_data_hi got %h want CAFE", tx_d); end
    n_tests++; if (cnt_words !== 32'd132 || cnt_commas !== 32'd36) begin n_fail++; $display("FAIL recover_counters got words=%0d commas=%0d want 132/36", cnt_words, cnt_commas); end
  endtask

  // Forced commas 172..390 (seq 36..254); timer comma at 454 merges with a force pulse (seq 255);
  // a later force gives seq 0.
  task automatic test_force_seq();
    logic [15:0] exp_lo;
    force_comma = 1'b1;
    tick();
    n_tests++; if (tx_d !== 16'hF7F7) begin n_fail++; $display("FAIL force_latch_slot got %h want F7F7", tx_d); end
    tick();
    for (int i = 0; i < 219; i++) begin
      if (i == 218) force_comma = 1'b0;
      tick();
      exp_lo = {8'(36 + i), 8'hBC};
      n_tests++; if (tx_d !== exp_lo || tx_k !== 2'b01) begin n_fail++; $display("FAIL force_comma_lo %0d got %h/%b want %h/01", i, tx_d, tx_k, exp_lo); end
      tick();
    end
    for (int s = 391; s <= 452; s++) begin
      tick(); tick();
    end
    n_tests++; if (tx_d !== 16'hF7F7) begin n_fail++; $display("FAIL force_idle_gap got %h want F7F7", tx_d); end
    tick();
    force_comma = 1'b1;
    tick();
    force_comma = 1'b0;
    n_tests++; if (in_rdy !== 1'b0) begin n_fail++; $display("FAIL merge_in_rdy got %b want 0", in_rdy); end
    tick();
    n_tests++; if (tx_d !== 16'hFFBC || tx_k !== 2'b01) begin n_fail++; $display("FAIL merge_comma_lo got %h/%b want FFBC/01", tx_d, tx_k); end
    tick();
    tick();
    n_tests++; if (tx_d !== 16'hF7F7 || tx_k !== 2'b11) begin n_fail++; $display("FAIL merge_single got %h/%b want F7F7/11", tx_d, tx_k); end
    force_comma = 1'b1;
    tick();
    force_comma = 1'b0;
    tick();
    n_tests++; if (tx_d !== 16'h00BC || tx_k !== 2'b01) begin n_fail++; $display("FAIL seq_wrap got %h/%b want 00BC/01", tx_d, tx_k); end
    tick();
  endtask

  // Slot 457: counter_reset coincides with a data word; clear must win.
  task automatic test_counter_reset();
    n_tests++; if (cnt_commas !== 32'd257 || cnt_words !== 32'd132 || cnt_bad !== 32'd1) begin n_fail++; $display("FAIL pre_clear_counters got %0d/%0d/%0d want 257/132/1", cnt_commas, cnt_words, cnt_bad); end
    in_v = 1'b1; in_d = 32'h01234567; in_k = 4'hF; counter_reset = 1'b1;
    tick();
    in_v = 1'b0; counter_reset = 1'b0;
    n_tests++; if ({cnt_words, cnt_commas, cnt_bad} !== 96'h0) begin n_fail++; $display("FAIL clear_counters got %0d/%0d/%0d want 0", cnt_words, cnt_commas, cnt_bad); end
    n_tests++; if (tx_d !== 16'h4567 || tx_k !== 2'b11) begin n_fail++; $display("FAIL kdata_lo got %h/%b want 4567/11", tx_d, tx_k); end
    tick();
    n_tests++; if (tx_d !== 16'h0123 || tx_k !== 2'b11) begin n_fail++; $display("FAIL kdata_hi got %h/%b want 0123/11", tx_d, tx_k); end
    tick();
    tick();
    n_tests++; if (cnt_words !== 32'd0) begin n_fail++; $display("FAIL post_clear_words got %0d want 0", cnt_words); end
  endtask

  initial begin
    test_reset();
    test_startup();
    test_data();
    test_pad_idle();
    test_continuous();
    test_link_drop();
    test_force_seq();
    test_counter_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
